// File: rtl/otp_prog_ctrl.sv
// Byte-level program/read controller for a bit-programmed OTP RAM.
// Writes are bit-serial with readback verify; bytes programmed since reset are refused.
module otp_prog_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              prog_en,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [2:0]        prog_bit,
  output logic              prog_data,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        read_data
);

  localparam int SIZE = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, PROG, VRD, VCMP, RD, RWAIT} state_e;
  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_REWRITE     = 2'd1,
    ST_VERIFY_FAIL = 2'd2
  } status_e;

  state_e            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [2:0]        bit_idx;
  logic [SIZE-1:0]   written;
  logic              accept;
  logic              refuse;

  assign accept    = cmd_valid && (state == IDLE);
  assign refuse    = accept && cmd_write && written[cmd_addr];
  assign cmd_ready = (state == IDLE);
  assign prog_en   = (state == PROG);
  assign read_en   = (state == VRD) || (state == RD);
  assign prog_bit  = bit_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and infers a latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept && !refuse) state_next = cmd_write ? PROG : RD;
      end
      PROG:    if (bit_idx == 3'd7) state_next = VRD;
      VRD:     state_next = VCMP;
      VCMP:    state_next = IDLE;
      RD:      state_next = RWAIT;
      RWAIT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM-side address/bit/data registers only move when their strobe is about
  // to rise, so they hold their last values while the strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      wdata      <= '0;
      bit_idx    <= '0;
      // NOTE: the shadow bitmap is a flat vector of flops, not a RAM, so it
      // can and must be cleared by reset.
      written    <= '0;
      prog_addr  <= '0;
      prog_data  <= 1'b0;
      read_addr  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
            if (refuse) begin
              rsp_valid  <= 1'b1;
              rsp_rdata  <= '0;
              rsp_status <= ST_REWRITE;
            end else if (cmd_write) begin
              bit_idx   <= '0;
              prog_addr <= cmd_addr;
              prog_data <= cmd_wdata[0];
            end else begin
              read_addr <= cmd_addr;
            end
          end
        end
        PROG: begin
          if (bit_idx != 3'd7) begin
            bit_idx   <= bit_idx + 3'd1;
            prog_data <= wdata[bit_idx + 3'd1];
          end else begin
            read_addr <= addr;
          end
        end
        VCMP: begin
          // Marked even on verify failure: the bits are burnt either way.
          written[addr] <= 1'b1;
          rsp_valid     <= 1'b1;
          rsp_rdata     <= read_data;
          rsp_status    <= (read_data == wdata) ? ST_OK : ST_VERIFY_FAIL;
        end
        RWAIT: begin
          rsp_valid  <= 1'b1;
          rsp_rdata  <= read_data;
          rsp_status <= ST_OK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_prog_ctrl.sv
// Directed bench for otp_prog_ctrl with a one-time-programmable RAM model and
// a response scoreboard keyed on status, data and arrival cycle.
module tb_otp_prog_ctrl;

  localparam int ADDR_W = 3;
  localparam int SIZE   = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [7:0]        cmd_wdata = '0;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic [1:0]        rsp_status;
  logic              prog_en;
  logic [ADDR_W-1:0] prog_addr;
  logic [2:0]        prog_bit;
  logic              prog_data;
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [7:0]        read_data = '0;

  otp_prog_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_bit(prog_bit), .prog_data(prog_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // OTP model: each bit takes the first value programmed into it; later pulses are ignored.
  logic [7:0] mem_val  [SIZE] = '{default: 8'h00};
  logic [7:0] mem_done [SIZE] = '{default: 8'h00};
  always @(posedge clk) begin
    if (prog_en && !mem_done[prog_addr][prog_bit]) begin
      mem_val[prog_addr][prog_bit]  <= prog_data;
      mem_done[prog_addr][prog_bit] <= 1'b1;
    end
    if (read_en) read_data <= mem_val[read_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] st;
    logic [7:0] rd;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor and strobe-exclusivity check.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        check("rsp_status", 32'(rsp_status), 32'(e.st));
        check("rsp_rdata",  32'(rsp_rdata),  32'(e.rd));
        check("rsp_cycle",  32'(cyc),        32'(e.cyc));
      end
    end
    if (prog_en || read_en) check("strobe_excl", 32'(prog_en & read_en), 0);
  end

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                       input bit want_rsp, input logic [1:0] st, input logic [7:0] rd,
                       input int lat, output int c0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    c0 = cyc;
    if (want_rsp) sb.push_back('{st, rd, c0 + lat});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic goto(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    #1;
    while (sb.size() != 0 && i < 60) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(tag, 32'(sb.size()), 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_prog_en", 32'(prog_en), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;
  endtask

  initial begin
    int         c0;
    logic [7:0] pat;

    // Reset values
    #12;
    check("rst_cmd_ready",  32'(cmd_ready), 1);
    check("rst_prog_en",    32'(prog_en), 0);
    check("rst_read_en",    32'(read_en), 0);
    check("rst_rsp_valid",  32'(rsp_valid), 0);
    check("rst_rsp_rdata",  32'(rsp_rdata), 0);
    check("rst_rsp_status", 32'(rsp_status), 0);
    check("rst_prog_bit",   32'(prog_bit), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh write addr 2 = 0xA5: cycle-by-cycle RAM strobes
    pat = 8'hA5;
    issue(1'b1, 3'd2, pat, 1'b1, 2'd0, 8'hA5, 11, c0);
    for (int n = 1; n <= 8; n++) begin
      goto(c0 + n);
      check("w_prog_en",   32'(prog_en), 1);
      check("w_prog_bit",  32'(prog_bit), 32'(n - 1));
      check("w_prog_data", 32'(prog_data), 32'(pat[n-1]));
      check("w_prog_addr", 32'(prog_addr), 2);
    end
    goto(c0 + 9);
    check("w_vrd_read_en", 32'(read_en), 1);
    check("w_vrd_addr",    32'(read_addr), 2);
    check("w_vrd_prog_en", 32'(prog_en), 0);
    goto(c0 + 10);
    check("w_vcmp_read_en", 32'(read_en), 0);
    check("w_vcmp_ready",   32'(cmd_ready), 0);
    check("w_hold_bit",     32'(prog_bit), 7);
    goto(c0 + 11);
    check("w_rsp_ready", 32'(cmd_ready), 1);
    drain("drain_w2");

    // Rewrite refused without RAM access
    issue(1'b1, 3'd2, 8'h00, 1'b1, 2'd1, 8'h00, 1, c0);
    goto(c0 + 1);
    check("rw_prog_en", 32'(prog_en), 0);
    check("rw_read_en", 32'(read_en), 0);
    check("rw_ready",   32'(cmd_ready), 1);
    drain("drain_rw");

    // Read back addr 2
    issue(1'b0, 3'd2, 8'h00, 1'b1, 2'd0, 8'hA5, 3, c0);
    goto(c0 + 1);
    check("rd_read_en", 32'(read_en), 1);
    check("rd_addr",    32'(read_addr), 2);
    drain("drain_rd");

    // Reset mid-PROG on addr 7. Pulse falls before the edge ending cycle 4,
    // so only bits 0..2 (0,0,1 from 0x3C) are burnt; 0xFF then sets bits 3..7.
    issue(1'b1, 3'd7, 8'h3C, 1'b0, 2'd0, 8'h00, 0, c0);
    goto(c0 + 4);
    #1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_prog_en", 32'(prog_en), 0);
    check("mid_rst_ready",   32'(cmd_ready), 1);
    rst_n = 1'b1;
    issue(1'b1, 3'd7, 8'hFF, 1'b1, 2'd2, 8'hFC, 11, c0);
    drain("drain_w7");
    issue(1'b0, 3'd7, 8'h00, 1'b1, 2'd0, 8'hFC, 3, c0);
    drain("drain_r7");

    // Same value rewritten after reset verifies OK; then refused again
    issue(1'b1, 3'd5, 8'h81, 1'b1, 2'd0, 8'h81, 11, c0);
    drain("drain_w5a");
    reset_pulse();
    issue(1'b1, 3'd5, 8'h81, 1'b1, 2'd0, 8'h81, 11, c0);
    drain("drain_w5b");
    issue(1'b1, 3'd5, 8'h81, 1'b1, 2'd1, 8'h00, 1, c0);
    drain("drain_w5c");

    // Back-to-back: read held behind a write, accepted in the response cycle
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd0;
    cmd_wdata = 8'h5A;
    c0 = cyc;
    sb.push_back('{2'd0, 8'h5A, c0 + 11});
    sb.push_back('{2'd0, 8'h5A, c0 + 14});
    @(posedge clk);
    #1;
    cmd_write = 1'b0;
    goto(c0 + 11);
    check("b2b_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain("drain_b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
